// File: rtl/alu_pkg.sv
// Shared opcode encodings and control state type for the sequential ALU.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_MULU = 6'd1;
  localparam logic [5:0] OP_MULS = 6'd2;
  localparam logic [5:0] OP_NEG  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_NEGI = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_XOR  = 6'd7;
  localparam logic [5:0] OP_SHL  = 6'd8;
  localparam logic [5:0] OP_SHR  = 6'd9;
  localparam logic [5:0] OP_SHLI = 6'd10;
  localparam logic [5:0] OP_SHRI = 6'd11;
  localparam logic [5:0] OP_SRA  = 6'd12;
  localparam logic [5:0] OP_SRAI = 6'd13;
  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;
  logic               running;
  logic [WIDTH:0]     sum;

  // busy drops during the final iteration so the controller can leave MUL on that same edge
  assign busy    = running && (count != '0);
  assign product = prod;
  assign sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      prod    <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      prod    <= {{WIDTH{1'b0}}, b};
      count   <= CW'(WIDTH - 1);
      running <= 1'b1;
    end else if (running) begin
      prod <= {sum, prod[WIDTH-1:1]};
      if (count == '0) running <= 1'b0;
      else             count   <= count - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops registered on accept, multiplies via the shift-add engine.
//   state | meaning
//   IDLE  | ready; single-cycle and illegal ops complete on the accepting edge
//   MUL   | multiplier iterating, input stalled
//   FIX   | apply product sign, load {high,result}, pulse out_valid
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       opcode,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] high,
  output logic             carry_flag,
  output logic             z_flag,
  output logic             sign_flag,
  output logic             overflow_flag,
  output logic             illegal_op
);

  localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

  state_t             state;
  logic               accept, is_mul, is_muls, neg_q;
  logic               mul_busy;
  logic [2*WIDTH-1:0] mul_product, fixed;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [WIDTH:0]     sum, ext_a, ext_b, abs_a, abs_b;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c, ovf_c, legal_c, big_shift;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_muls  = ENABLE_MUL && (opcode == OP_MULS);
  assign is_mul   = ENABLE_MUL && ((opcode == OP_MULU) || (opcode == OP_MULS));

  // Magnitudes in WIDTH+1 bits so the most negative operand stays exact
  assign ext_a = {a[WIDTH-1], a};
  assign ext_b = {b[WIDTH-1], b};
  assign abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
  assign abs_b = ext_b[WIDTH] ? -ext_b : ext_b;
  assign mul_a = is_muls ? abs_a[WIDTH-1:0] : a;
  assign mul_b = is_muls ? abs_b[WIDTH-1:0] : b;
  assign fixed = neg_q ? -mul_product : mul_product;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign big_shift = (b >= W_VAL);

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    legal_c = 1'b1;
    case (opcode)
      OP_ADD, OP_ADDI, OP_LW, OP_SW: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NEG, OP_NEGI: res_c = -b;
      OP_AND:          res_c = a & b;
      OP_XOR:          res_c = a ^ b;
      OP_SHL, OP_SHLI: res_c = big_shift ? '0 : (a << b);
      OP_SHR, OP_SHRI: res_c = big_shift ? '0 : (a >> b);
      OP_SRA, OP_SRAI: res_c = big_shift ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
      default:         legal_c = 1'b0;
    endcase
  end

  generate
    if (ENABLE_MUL) begin : g_mul
      seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && is_mul),
        .a       (mul_a),
        .b       (mul_b),
        .busy    (mul_busy),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      neg_q         <= 1'b0;
      out_valid     <= 1'b0;
      result        <= '0;
      high          <= '0;
      carry_flag    <= 1'b0;
      z_flag        <= 1'b1;
      sign_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_mul) begin
            neg_q <= is_muls && (a[WIDTH-1] ^ b[WIDTH-1]);
            state <= MUL;
          end else if (legal_c) begin
            result        <= res_c;
            z_flag        <= (res_c == '0);
            sign_flag     <= res_c[WIDTH-1];
            carry_flag    <= carry_c;
            overflow_flag <= ovf_c;
            illegal_op    <= 1'b0;
            out_valid     <= 1'b1;
          end else begin
            result        <= '0;
            high          <= '0;
            z_flag        <= 1'b1;
            sign_flag     <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
            illegal_op    <= 1'b1;
            out_valid     <= 1'b1;
          end
        end
        MUL: if (!mul_busy) state <= FIX;
        FIX: begin
          {high, result} <= fixed;
          z_flag         <= (fixed == '0);
          sign_flag      <= 1'b0;
          carry_flag     <= 1'b0;
          overflow_flag  <= 1'b0;
          illegal_op     <= 1'b0;
          out_valid      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized checks of seq_alu against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [5:0]  opcode = '0;
  logic        out_valid;
  logic [31:0] result, high;
  logic        carry_flag, z_flag, sign_flag, overflow_flag, illegal_op;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res, hi;
    logic        c, z, s, v, ill;
    int          lat;
  } exp_t;

  logic [31:0] model_high = '0;

  seq_alu #(.WIDTH(32), .ENABLE_MUL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .result(result),
    .high(high), .carry_flag(carry_flag), .z_flag(z_flag), .sign_flag(sign_flag),
    .overflow_flag(overflow_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input int op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] hi_prev);
    exp_t e;
    longint sx, sy, sv;
    logic [63:0] p;
    logic [32:0] s33;
    e.res = '0; e.hi = hi_prev; e.c = 0; e.v = 0; e.ill = 0; e.lat = 0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      0, 4, 16, 32: begin
        s33 = {1'b0, x} + {1'b0, y};
        e.res = s33[31:0];
        e.c = s33[32];
        sv = sx + sy;
        e.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      1, 2: begin
        if (op == 1) p = {32'b0, x} * {32'b0, y};
        else         p = sx * sy;
        e.res = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
      3, 5:   e.res = 32'd0 - y;
      6:      e.res = x & y;
      7:      e.res = x ^ y;
      8, 10:  e.res = (y >= 32) ? 32'd0 : x << y;
      9, 11:  e.res = (y >= 32) ? 32'd0 : x >> y;
      12, 13: begin
        sv = (y >= 32) ? ((sx < 0) ? -64'sd1 : 64'sd0) : (sx >>> y);
        e.res = sv[31:0];
      end
      default: begin e.ill = 1; e.hi = '0; end
    endcase
    e.z = (op == 1 || op == 2) ? ({e.hi, e.res} == 64'd0) : (e.res == 32'd0);
    e.s = (op == 1 || op == 2 || e.ill) ? 1'b0 : e.res[31];
    return e;
  endfunction

  task automatic do_op(input int op, input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    int n, low;
    e = model(op, x, y, model_high);
    @(negedge clk);
    chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    a = x; b = y; opcode = 6'(op); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; low = 0;
    while (!out_valid && n < 100) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(e.lat));
    if (e.lat != 0) chk({tag, ".stall"}, 64'(low), 64'(e.lat));
    chk({tag, ".result"}, {32'd0, result}, {32'd0, e.res});
    chk({tag, ".high"},   {32'd0, high},   {32'd0, e.hi});
    chk({tag, ".flags"},  {59'd0, carry_flag, z_flag, sign_flag, overflow_flag, illegal_op},
                          {59'd0, e.c, e.z, e.s, e.v, e.ill});
    model_high = e.hi;
    @(posedge clk); #1;
    chk({tag, ".pulse"}, {63'd0, out_valid}, 64'd0);
  endtask

  localparam int NPOOL = 18;
  int pool [NPOOL] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 32, 14, 63};

  initial begin
    int op, hits;
    logic [31:0] x, y;
    exp_t e;

    #12;
    chk("reset.result", {32'd0, result}, 64'd0);
    chk("reset.high", {32'd0, high}, 64'd0);
    chk("reset.flags", {58'd0, out_valid, carry_flag, z_flag, sign_flag, overflow_flag, illegal_op},
        {58'd0, 6'b001000});
    chk("reset.in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;

    do_op(0, 32'h7FFFFFFF, 32'h00000001, "add_ovf");
    do_op(0, 32'hFFFFFFFF, 32'h00000001, "add_carry");

    // back-to-back issue: two consecutive pulses
    e = model(0, 32'hFFFFFFFF, 32'h00000001, model_high);
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; opcode = 6'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b.first", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.second", {63'd0, out_valid}, 64'd1);
    chk("b2b.result", {32'd0, result}, {32'd0, e.res});
    @(posedge clk); #1;
    chk("b2b.idle", {63'd0, out_valid}, 64'd0);

    do_op(2, 32'hFFFFFFFD, 32'd5, "muls_neg");
    do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulu_max");
    do_op(6, 32'h000000F0, 32'h0000000F, "and_zero");
    do_op(2, 32'h80000000, 32'h80000000, "muls_minmin");
    do_op(2, 32'h80000000, 32'd1, "muls_min1");
    do_op(12, 32'h80000000, 32'd40, "sra_big");
    do_op(8, 32'd1, 32'd32, "shl_32");
    do_op(9, 32'h80000000, 32'd31, "shr_31");
    do_op(13, 32'h7FFFFFFF, 32'hFFFFFFFF, "sra_pos_huge");
    do_op(3, 32'd0, 32'h80000000, "neg_min");
    do_op(1, 32'd0, 32'h12345678, "mulu_zero");

    // reset during a multiply
    @(negedge clk);
    a = 32'h12345; b = 32'h6789; opcode = 6'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.result", {32'd0, result}, 64'd0);
    chk("midrst.high", {32'd0, high}, 64'd0);
    chk("midrst.flags", {58'd0, out_valid, carry_flag, z_flag, sign_flag, overflow_flag, illegal_op},
        {58'd0, 6'b001000});
    chk("midrst.in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    model_high = '0;
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) hits++;
    end
    chk("midrst.no_pulse", 64'(hits), 64'd0);
    do_op(63, 32'hDEADBEEF, 32'h1, "illegal63");

    repeat (40) begin
      op = pool[$urandom_range(NPOOL - 1)];
      if ($urandom_range(3) == 0) op = $urandom_range(63);
      x = $urandom;
      y = $urandom;
      if (op >= 8 && op <= 13 && $urandom_range(1) == 0) y = $urandom_range(40);
      do_op(op, x, y, $sformatf("rnd_op%0d", op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
